// File: rtl/cursor_ctrl.sv
// VT52 cursor unit: cursor position, screen-edge clamping/auto-wrap,
// scroll request handshake to the video RAM controller, and blink phase.
module cursor_ctrl #(
    parameter int unsigned ROW_BITS     = 5,
    parameter int unsigned COL_BITS     = 7,
    parameter int unsigned ROWS         = 24,
    parameter int unsigned COLS         = 80,
    parameter int unsigned BLINK_FRAMES = 15,
    parameter int unsigned WRAP         = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vblank,
    input  logic                cursor_enable,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [COL_BITS-1:0] cmd_x,
    input  logic [ROW_BITS-1:0] cmd_y,
    output logic [COL_BITS-1:0] cursor_x,
    output logic [ROW_BITS-1:0] cursor_y,
    output logic                cursor_blink_on,
    output logic                scroll_req,
    input  logic                scroll_ack
);

    localparam logic [COL_BITS-1:0] X_MAX    = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] Y_MAX    = ROW_BITS'(ROWS - 1);
    localparam int unsigned         CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'((BLINK_FRAMES > 0) ? (BLINK_FRAMES - 1) : 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_CR    = 3'd0,
        OP_SET   = 3'd1,
        OP_UP    = 3'd2,
        OP_DOWN  = 3'd3,
        OP_LEFT  = 3'd4,
        OP_RIGHT = 3'd5,
        OP_HOME  = 3'd6,
        OP_LF    = 3'd7
    } op_e;

    state_e              state_q, state_d;
    logic [COL_BITS-1:0] x_q, x_d;
    logic [ROW_BITS-1:0] y_q, y_d;
    logic                phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                vblank_q;

    logic accept;
    logic vb_edge;
    logic at_right;
    logic at_bottom;

    assign accept    = cmd_valid && (state_q == S_IDLE);
    assign vb_edge   = vblank && !vblank_q;
    assign at_right  = (x_q >= X_MAX);
    assign at_bottom = (y_q >= Y_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            phase_q  <= 1'b1;
            cnt_q    <= '0;
            vblank_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            vblank_q <= vblank;
        end
    end

    // Command execution, scroll handshake and blink phase.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;

        if (accept) begin
            case (op_e'(cmd_op))
                OP_CR:   x_d = '0;
                OP_SET: begin
                    x_d = (cmd_x > X_MAX) ? X_MAX : cmd_x;
                    y_d = (cmd_y > Y_MAX) ? Y_MAX : cmd_y;
                end
                OP_UP:   if (y_q != '0) y_d = y_q - ROW_BITS'(1);
                OP_DOWN: if (!at_bottom) y_d = y_q + ROW_BITS'(1);
                OP_LEFT: if (x_q != '0) x_d = x_q - COL_BITS'(1);
                OP_RIGHT: begin
                    if (!at_right) begin
                        x_d = x_q + COL_BITS'(1);
                    end else if (WRAP != 0) begin
                        x_d = '0;
                        if (!at_bottom) y_d = y_q + ROW_BITS'(1);
                        else            state_d = S_WAIT;
                    end
                end
                OP_HOME: begin
                    x_d = '0;
                    y_d = '0;
                end
                OP_LF: begin
                    if (!at_bottom) y_d = y_q + ROW_BITS'(1);
                    else            state_d = S_WAIT;
                end
                default: ;
            endcase
        end else if ((state_q == S_WAIT) && scroll_ack) begin
            state_d = S_IDLE;
        end

        // Any accepted command restarts the blink so the cursor is visible while typing.
        if (BLINK_FRAMES == 0) begin
            phase_d = 1'b1;
            cnt_d   = '0;
        end else if (accept) begin
            phase_d = 1'b1;
            cnt_d   = '0;
        end else if (vb_edge) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = !phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign cursor_x        = x_q;
    assign cursor_y        = y_q;
    assign scroll_req      = (state_q == S_WAIT);
    assign cmd_ready       = (state_q == S_IDLE);
    assign cursor_blink_on = cursor_enable && phase_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: a wrapping and a clamping instance share stimulus and
// are checked every cycle against a behavioural model, plus literal spot checks.
module tb_cursor_ctrl;

    localparam int ROWS = 24;
    localparam int COLS = 80;
    localparam int BF   = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       vblank = 1'b0;
    logic       cursor_enable = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [6:0] cmd_x = 7'd0;
    logic [4:0] cmd_y = 5'd0;
    logic       scroll_ack = 1'b0;

    logic [6:0] dx   [2];
    logic [4:0] dy   [2];
    logic       drdy [2];
    logic       dreq [2];
    logic       dbl  [2];

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    // model state, index 0 = WRAP=1 instance, index 1 = WRAP=0 instance
    int mx [2] = '{0, 0};
    int my [2] = '{0, 0};
    int mreq [2] = '{0, 0};
    int mph [2] = '{1, 1};
    int mfr [2] = '{0, 0};
    int mvb [2] = '{0, 0};

    always #5 clk = ~clk;

    cursor_ctrl #(.WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .vblank(vblank), .cursor_enable(cursor_enable),
        .cmd_valid(cmd_valid), .cmd_ready(drdy[0]), .cmd_op(cmd_op), .cmd_x(cmd_x),
        .cmd_y(cmd_y), .cursor_x(dx[0]), .cursor_y(dy[0]), .cursor_blink_on(dbl[0]),
        .scroll_req(dreq[0]), .scroll_ack(scroll_ack)
    );

    cursor_ctrl #(.WRAP(0)) dut_c (
        .clk(clk), .reset(reset), .vblank(vblank), .cursor_enable(cursor_enable),
        .cmd_valid(cmd_valid), .cmd_ready(drdy[1]), .cmd_op(cmd_op), .cmd_x(cmd_x),
        .cmd_y(cmd_y), .cursor_x(dx[1]), .cursor_y(dy[1]), .cursor_blink_on(dbl[1]),
        .scroll_req(dreq[1]), .scroll_ack(scroll_ack)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written from the screen rules with plain integers.
    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                mx[i] = 0; my[i] = 0; mreq[i] = 0; mph[i] = 1; mfr[i] = 0; mvb[i] = 0;
            end else begin
                bit accepted;
                bit rising;
                accepted = cmd_valid && (mreq[i] == 0);
                rising   = vblank && (mvb[i] == 0);
                mvb[i]   = int'(vblank);
                if (accepted) begin
                    case (cmd_op)
                        3'd0: mx[i] = 0;
                        3'd1: begin
                            mx[i] = (int'(cmd_x) < COLS) ? int'(cmd_x) : COLS - 1;
                            my[i] = (int'(cmd_y) < ROWS) ? int'(cmd_y) : ROWS - 1;
                        end
                        3'd2: my[i] = (my[i] > 0) ? my[i] - 1 : 0;
                        3'd3: my[i] = (my[i] < ROWS - 1) ? my[i] + 1 : ROWS - 1;
                        3'd4: mx[i] = (mx[i] > 0) ? mx[i] - 1 : 0;
                        3'd5: begin
                            if (mx[i] < COLS - 1) mx[i] = mx[i] + 1;
                            else if (i == 0) begin
                                mx[i] = 0;
                                if (my[i] < ROWS - 1) my[i] = my[i] + 1;
                                else mreq[i] = 1;
                            end
                        end
                        3'd6: begin mx[i] = 0; my[i] = 0; end
                        default: begin
                            if (my[i] < ROWS - 1) my[i] = my[i] + 1;
                            else mreq[i] = 1;
                        end
                    endcase
                    mph[i] = 1;
                    mfr[i] = 0;
                end else begin
                    if (mreq[i] == 1 && scroll_ack) mreq[i] = 0;
                    if (rising) begin
                        mfr[i] = mfr[i] + 1;
                        if (mfr[i] == BF) begin
                            mfr[i] = 0;
                            mph[i] = 1 - mph[i];
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp && reset) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cyc%0d.x", i), int'(dx[i]), mx[i]);
                chk($sformatf("cyc%0d.y", i), int'(dy[i]), my[i]);
                chk($sformatf("cyc%0d.scroll_req", i), int'(dreq[i]), mreq[i]);
                chk($sformatf("cyc%0d.cmd_ready", i), int'(drdy[i]), 1 - mreq[i]);
                chk($sformatf("cyc%0d.blink_on", i), int'(dbl[i]), int'(cursor_enable) & mph[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [6:0] x, input logic [4:0] y);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            vblank = 1'b1;
            tick();
            vblank = 1'b0;
            tick();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        run_cmp = 1'b1;
        #1;
        chk("rst.x", int'(dx[0]), 0);
        chk("rst.y", int'(dy[0]), 0);
        chk("rst.scroll_req", int'(dreq[0]), 0);
        chk("rst.cmd_ready", int'(drdy[0]), 1);
        chk("rst.blink_on", int'(dbl[0]), 1);
        tick();

        do_cmd(3'd1, 7'd100, 5'd30);
        chk("set.x", int'(dx[0]), 79);
        chk("set.y", int'(dy[0]), 23);
        repeat (3) do_cmd(3'd4, 7'd0, 5'd0);
        chk("left3.x", int'(dx[0]), 76);

        do_cmd(3'd1, 7'd79, 5'd23);
        do_cmd(3'd5, 7'd0, 5'd0);
        chk("wrap.x", int'(dx[0]), 0);
        chk("wrap.y", int'(dy[0]), 23);
        chk("wrap.scroll_req", int'(dreq[0]), 1);
        chk("wrap.cmd_ready", int'(drdy[0]), 0);
        chk("clamp.x", int'(dx[1]), 79);
        chk("clamp.scroll_req", int'(dreq[1]), 0);

        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        repeat (5) tick();
        chk("hold.scroll_req", int'(dreq[0]), 1);
        chk("hold.x", int'(dx[0]), 0);
        scroll_ack = 1'b1;
        tick();
        scroll_ack = 1'b0;
        chk("ack.scroll_req", int'(dreq[0]), 0);
        chk("ack.cmd_ready", int'(drdy[0]), 1);
        tick();
        cmd_valid = 1'b0;
        chk("down.y", int'(dy[0]), 23);

        do_cmd(3'd6, 7'd0, 5'd0);
        do_cmd(3'd2, 7'd0, 5'd0);
        chk("up0.y", int'(dy[1]), 0);

        pulses(14);
        chk("blink14", int'(dbl[0]), 1);
        pulses(1);
        chk("blink15", int'(dbl[0]), 0);
        pulses(15);
        chk("blink30", int'(dbl[0]), 1);
        pulses(14);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        vblank    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        vblank    = 1'b0;
        tick();
        chk("blink_cmd", int'(dbl[0]), 1);
        pulses(14);
        chk("blink_restart14", int'(dbl[0]), 1);
        pulses(1);
        chk("blink_restart15", int'(dbl[0]), 0);
        cursor_enable = 1'b0;
        #1;
        chk("enable0", int'(dbl[0]), 0);
        cursor_enable = 1'b1;
        tick();

        for (int c = 0; c < 3000; c++) begin
            int pv;
            pv = (c < 1500) ? 3 : 12;
            cmd_valid     = ($urandom_range(0, 15) < pv);
            cmd_op        = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 3'd5 : 3'd7)
                                                        : 3'($urandom_range(0, 7));
            cmd_x         = 7'($urandom_range(0, 127));
            cmd_y         = 5'($urandom_range(0, 31));
            scroll_ack    = ($urandom_range(0, 3) == 0);
            vblank        = ($urandom_range(0, 1) == 0);
            cursor_enable = ($urandom_range(0, 7) != 0);
            tick();
        end
        cmd_valid     = 1'b0;
        vblank        = 1'b0;
        cursor_enable = 1'b1;
        scroll_ack    = 1'b1;
        repeat (2) tick();
        scroll_ack = 1'b0;

        do_cmd(3'd1, 7'd79, 5'd23);
        do_cmd(3'd5, 7'd0, 5'd0);
        chk("prerst.scroll_req", int'(dreq[0]), 1);
        reset = 1'b0;
        #1;
        chk("asyncrst.scroll_req", int'(dreq[0]), 0);
        chk("asyncrst.x", int'(dx[0]), 0);
        chk("asyncrst.y", int'(dy[0]), 0);
        chk("asyncrst.cmd_ready", int'(drdy[0]), 1);
        tick();
        reset = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
